// File: rtl/spi_flash_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spi_flash_arbiter
// Description : Two-requester (CPU/DMA) arbiter for one SPI flash; issues
//               READ (0x03) in mode 0 at clk/2 and returns little-endian words.
//               Optional continuous-read mode: SPI_FLASH_ARB_CONTINUOUS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_flash_arbiter #(
    parameter int CSN_HIGH_CYCLES = 4,
    parameter int HOLD_CYCLES     = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_req_valid,
    input  logic [21:0] cpu_req_addr,
    output logic        cpu_req_ready,
    output logic [31:0] cpu_rdata,
    output logic        cpu_rdata_valid,
    input  logic        dma_req_valid,
    input  logic [21:0] dma_req_addr,
    input  logic [7:0]  dma_req_len,
    output logic        dma_req_ready,
    output logic [31:0] dma_rdata,
    output logic        dma_rdata_valid,
    output logic        dma_done,
    output logic        flash_sck,
    output logic        flash_csn,
    output logic        flash_mosi,
    input  logic        flash_miso
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_ADDR = 3'd2,
        ST_DATA = 3'd3,
        ST_GAP  = 3'd4
`ifdef SPI_FLASH_ARB_CONTINUOUS_EN
        ,
        ST_HOLD = 3'd5
`endif
    } state_t;

    // One timer serves both the CSN-high gap and the continuous-mode hold window.
    localparam int                 c_tmr_w    = $clog2(CSN_HIGH_CYCLES + HOLD_CYCLES + 1);
    localparam logic [c_tmr_w-1:0] c_gap_last = c_tmr_w'(CSN_HIGH_CYCLES - 1);
    localparam logic [c_tmr_w-1:0] c_tmr_one  = c_tmr_w'(1);
`ifdef SPI_FLASH_ARB_CONTINUOUS_EN
    localparam logic [c_tmr_w-1:0] c_hold_last = c_tmr_w'(HOLD_CYCLES - 1);
`endif

    state_t               r_state;
    logic                 r_last_dma;
    logic                 r_grant_dma;
    logic                 r_entry;
    logic [21:0]          r_addr;
    logic [7:0]           r_remain;
    logic [4:0]           r_bit_cnt;
    logic [31:0]          r_shift_out;
    logic [31:0]          r_shift_in;
    logic [c_tmr_w-1:0]   r_timer;
    logic                 r_cpu_ready;
    logic                 r_dma_ready;
    logic                 r_cpu_valid;
    logic                 r_dma_valid;
    logic                 r_dma_done;
    logic [31:0]          r_cpu_rdata;
    logic [31:0]          r_dma_rdata;
    logic                 r_sck;
    logic                 r_csn;
    logic                 r_mosi;

    logic                 w_any_req;
    logic                 w_grant_dma;
    logic [21:0]          w_req_addr;
    logic [7:0]           w_req_len;
    logic [31:0]          w_word;

    // Ties go to whichever requester was not served last.
    assign w_any_req   = cpu_req_valid | dma_req_valid;
    assign w_grant_dma = dma_req_valid & (~cpu_req_valid | ~r_last_dma);
    assign w_req_addr  = w_grant_dma ? dma_req_addr : cpu_req_addr;
    assign w_req_len   = w_grant_dma ? dma_req_len : 8'd0;

    // Bytes arrive b0 first, so the first byte shifted in lands in the top lane.
    assign w_word = {r_shift_in[7:0], r_shift_in[15:8], r_shift_in[23:16], r_shift_in[31:24]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_last_dma  <= 1'b1;
            r_grant_dma <= 1'b0;
            r_entry     <= 1'b0;
            r_addr      <= '0;
            r_remain    <= '0;
            r_bit_cnt   <= '0;
            r_shift_out <= '0;
            r_shift_in  <= '0;
            r_timer     <= '0;
            r_cpu_ready <= 1'b0;
            r_dma_ready <= 1'b0;
            r_cpu_valid <= 1'b0;
            r_dma_valid <= 1'b0;
            r_dma_done  <= 1'b0;
            r_cpu_rdata <= '0;
            r_dma_rdata <= '0;
            r_sck       <= 1'b0;
            r_csn       <= 1'b1;
            r_mosi      <= 1'b0;
        end else begin
            r_cpu_ready <= 1'b0;
            r_dma_ready <= 1'b0;
            r_cpu_valid <= 1'b0;
            r_dma_valid <= 1'b0;
            r_dma_done  <= 1'b0;
            r_cpu_rdata <= '0;
            r_dma_rdata <= '0;

            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_cpu_ready <= ~w_grant_dma;
                        r_dma_ready <= w_grant_dma;
                        r_grant_dma <= w_grant_dma;
                        r_last_dma  <= w_grant_dma;
                        r_addr      <= w_req_addr;
                        r_remain    <= w_req_len;
                        r_shift_out <= {8'h03, w_req_addr, 2'b00};
                        r_bit_cnt   <= '0;
                        r_entry     <= 1'b1;
                        r_state     <= ST_CMD;
                    end
                end

                ST_CMD, ST_ADDR: begin
                    if (r_entry) begin
                        r_entry <= 1'b0;
                        r_csn   <= 1'b0;
                        r_mosi  <= r_shift_out[31];
                    end else if (!r_sck) begin
                        r_sck <= 1'b1;
                    end else begin
                        r_sck       <= 1'b0;
                        r_bit_cnt   <= r_bit_cnt + 5'd1;
                        r_shift_out <= {r_shift_out[30:0], 1'b0};
                        r_mosi      <= r_shift_out[30];
                        if (r_bit_cnt == 5'd7) begin
                            r_state <= ST_ADDR;
                        end
                        if (r_bit_cnt == 5'd31) begin
                            r_state <= ST_DATA;
                        end
                    end
                end

                ST_DATA: begin
                    if (r_entry) begin
                        r_entry <= 1'b0;
                    end else if (!r_sck) begin
                        r_sck      <= 1'b1;
                        r_shift_in <= {r_shift_in[30:0], flash_miso};
                    end else begin
                        r_sck     <= 1'b0;
                        r_bit_cnt <= r_bit_cnt + 5'd1;
                        if (r_bit_cnt == 5'd31) begin
                            if (r_grant_dma) begin
                                r_dma_valid <= 1'b1;
                                r_dma_rdata <= w_word;
                            end else begin
                                r_cpu_valid <= 1'b1;
                                r_cpu_rdata <= w_word;
                            end
                            r_addr   <= r_addr + 22'd1;
                            r_remain <= r_remain - 8'd1;
                            if (r_remain == 8'd0) begin
                                r_dma_done <= r_grant_dma;
                                r_timer    <= '0;
`ifdef SPI_FLASH_ARB_CONTINUOUS_EN
                                r_state    <= ST_HOLD;
`else
                                r_csn      <= 1'b1;
                                r_state    <= ST_GAP;
`endif
                            end
                        end
                    end
                end

                ST_GAP: begin
                    if (r_timer == c_gap_last) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_timer <= r_timer + c_tmr_one;
                    end
                end

`ifdef SPI_FLASH_ARB_CONTINUOUS_EN
                // CS is still low and the flash is still streaming from r_addr.
                ST_HOLD: begin
                    if (w_any_req && (w_req_addr == r_addr)) begin
                        r_cpu_ready <= ~w_grant_dma;
                        r_dma_ready <= w_grant_dma;
                        r_grant_dma <= w_grant_dma;
                        r_last_dma  <= w_grant_dma;
                        r_remain    <= w_req_len;
                        r_bit_cnt   <= '0;
                        r_entry     <= 1'b1;
                        r_state     <= ST_DATA;
                    end else if (w_any_req || (r_timer == c_hold_last)) begin
                        r_csn   <= 1'b1;
                        r_timer <= '0;
                        r_state <= ST_GAP;
                    end else begin
                        r_timer <= r_timer + c_tmr_one;
                    end
                end
`endif

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cpu_req_ready   = r_cpu_ready;
    assign dma_req_ready   = r_dma_ready;
    assign cpu_rdata_valid = r_cpu_valid;
    assign dma_rdata_valid = r_dma_valid;
    assign dma_done        = r_dma_done;
    assign cpu_rdata       = r_cpu_rdata;
    assign dma_rdata       = r_dma_rdata;
    assign flash_sck       = r_sck;
    assign flash_csn       = r_csn;
    assign flash_mosi      = r_mosi;

endmodule
`default_nettype wire
